// File: rtl/watch_pkg.sv
// Shared display-code field positions, segment type and scan state encoding
// for the watch display path.
package watch_pkg;

   localparam int CODE_EN     = 5;
   localparam int CODE_VAL_HI = 4;
   localparam int CODE_VAL_LO = 1;
   localparam int CODE_DP     = 0;

   typedef logic [5:0] disp_code_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg7_scan_driver_hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order a..g (MSB = a).
module hex7seg
   import watch_pkg::*;
(
   input  logic [3:0] i_val,
   output seg_t       o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_val)
         4'h0: o_seg = 7'b0000001;
         4'h1: o_seg = 7'b1001111;
         4'h2: o_seg = 7'b0010010;
         4'h3: o_seg = 7'b0000110;
         4'h4: o_seg = 7'b1001100;
         4'h5: o_seg = 7'b0100100;
         4'h6: o_seg = 7'b0100000;
         4'h7: o_seg = 7'b0001111;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0000100;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b1100000;
         4'hC: o_seg = 7'b0110001;
         4'hD: o_seg = 7'b1000010;
         4'hE: o_seg = 7'b0110000;
         4'hF: o_seg = 7'b0111000;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode multiplexed display scanner: each lit digit slot is
// preceded by an all-off gap, and a whole frame shows one snapshot of the codes.
module seg7_scan_driver
   import watch_pkg::*;
#(
   parameter int ON_CYCLES    = 100_000,
   parameter int BLANK_CYCLES = 1_000
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_ni,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   output logic [7:0] an_o,
   output logic [7:0] dec_ddp_o,
   output logic       frame_o
);

   localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC);

   scan_state_t  r_state;
   logic [2:0]   r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]   r_an;
   logic [7:0]   r_dec;
   logic         r_frame;
   disp_code_t   r_snap [8];

   disp_code_t   w_codes [8];
   disp_code_t   w_cur;
   seg_t         w_seg;
   logic         w_snap_en;
   logic         w_blank_done;
   logic         w_on_done;

   assign w_codes[0] = d1;
   assign w_codes[1] = d2;
   assign w_codes[2] = d3;
   assign w_codes[3] = d4;
   assign w_codes[4] = d5;
   assign w_codes[5] = d6;
   assign w_codes[6] = d7;
   assign w_codes[7] = d8;

   // Snapshot at the very start of a frame so every slot of it sees the same codes.
   assign w_snap_en    = (r_state == BLANK) && (r_idx == 3'd0) && (r_cnt == '0);
   assign w_blank_done = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
   assign w_on_done    = (r_cnt == CNT_W'(ON_CYCLES - 1));
   assign w_cur        = r_snap[r_idx];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_snap
         always_ff @(posedge clk_100MHz_i or negedge reset_ni) begin
            if (!reset_ni) begin
               r_snap[gi] <= '0;
            end else if (w_snap_en) begin
               r_snap[gi] <= w_codes[gi];
            end
         end
      end
   endgenerate

   hex7seg u_hex7seg (
      .i_val (w_cur[CODE_VAL_HI:CODE_VAL_LO]),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk_100MHz_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= BLANK;
         r_idx   <= 3'd0;
         r_cnt   <= '0;
         r_an    <= 8'hFF;
         r_dec   <= 8'hFF;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_snap_en;
         case (r_state)
            BLANK: begin
               if (w_blank_done) begin
                  r_state <= ON;
                  r_cnt   <= '0;
                  if (w_cur[CODE_EN]) begin
                     r_an  <= ~(8'b1 << r_idx);
                     r_dec <= {w_seg, w_cur[CODE_DP]};
                  end else begin
                     r_an  <= 8'hFF;
                     r_dec <= 8'hFF;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ON: begin
               if (w_on_done) begin
                  r_state <= BLANK;
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 3'd1;
                  r_an    <= 8'hFF;
                  r_dec   <= 8'hFF;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= BLANK;
               r_cnt   <= '0;
               r_an    <= 8'hFF;
               r_dec   <= 8'hFF;
            end
         endcase
      end
   end

   assign an_o      = r_an;
   assign dec_ddp_o = r_dec;
   assign frame_o   = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with ON_CYCLES=4, BLANK_CYCLES=2 (48-clock frame).
module tb_seg7_scan_driver;

   localparam int ON_C  = 4;
   localparam int BL_C  = 2;
   localparam int SLOT  = ON_C + BL_C;
   localparam int FRAME = 8 * SLOT;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] dec;
   } slot_t;

   logic       clk = 1'b0;
   logic       reset_ni;
   logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
   logic [7:0] an_o;
   logic [7:0] dec_ddp_o;
   logic       frame_o;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    pos      = 0;
   slot_t exp_q[$];
   slot_t cur;
   logic [6:0] seg_tab [16];

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .ON_CYCLES    (ON_C),
      .BLANK_CYCLES (BL_C)
   ) dut (
      .clk_100MHz_i (clk),
      .reset_ni     (reset_ni),
      .d1           (d1),
      .d2           (d2),
      .d3           (d3),
      .d4           (d4),
      .d5           (d5),
      .d6           (d6),
      .d7           (d7),
      .d8           (d8),
      .an_o         (an_o),
      .dec_ddp_o    (dec_ddp_o),
      .frame_o      (frame_o)
   );

   function automatic logic [5:0] get_d(input int i);
      case (i)
         0: get_d = d1;
         1: get_d = d2;
         2: get_d = d3;
         3: get_d = d4;
         4: get_d = d5;
         5: get_d = d6;
         6: get_d = d7;
         default: get_d = d8;
      endcase
   endfunction

   function automatic slot_t mk_slot(input int idx, input logic [5:0] code);
      slot_t      s;
      logic [7:0] one;
      one = 8'b1;
      if (code[5]) begin
         s.an  = ~(one << idx);
         s.dec = {seg_tab[code[4:1]], code[0]};
      end else begin
         s.an  = 8'hFF;
         s.dec = 8'hFF;
      end
      return s;
   endfunction

   task automatic push_frame();
      for (int i = 0; i < 8; i++) exp_q.push_back(mk_slot(i, get_d(i)));
   endtask

   task automatic set_all(input logic [5:0] v);
      d1 = v; d2 = v; d3 = v; d4 = v; d5 = v; d6 = v; d7 = v; d8 = v;
   endtask

   // Steps n clocks from the current frame position, checking every cycle;
   // optionally rewrites d1 right after the edge at frame position chg_pos.
   task automatic run_check(input int n, input int chg_pos, input logic [5:0] chg_val,
                            input string tag);
      int         p;
      int         ph;
      logic [7:0] e_an;
      logic [7:0] e_dec;
      logic       e_frame;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         p   = pos;
         pos = (pos + 1) % FRAME;
         ph  = p % SLOT;
         if (ph == BL_C - 1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s scoreboard_empty at pos %0d: got nothing, need a slot entry", tag, p);
               cur = '{an: 8'hFF, dec: 8'hFF};
            end else begin
               cur = exp_q.pop_front();
               $display("%s slot %0d: expect an=%02h dec=%02h", tag, p / SLOT, cur.an, cur.dec);
            end
         end
         if (ph >= BL_C - 1 && ph <= BL_C + ON_C - 2) begin
            e_an  = cur.an;
            e_dec = cur.dec;
         end else begin
            e_an  = 8'hFF;
            e_dec = 8'hFF;
         end
         e_frame = (p == 0);
         n_checks++;
         if (an_o !== e_an) begin
            n_fail++;
            $display("FAIL %s an_o pos %0d: got %02h need %02h", tag, p, an_o, e_an);
         end
         n_checks++;
         if (dec_ddp_o !== e_dec) begin
            n_fail++;
            $display("FAIL %s dec_ddp_o pos %0d: got %02h need %02h", tag, p, dec_ddp_o, e_dec);
         end
         n_checks++;
         if (frame_o !== e_frame) begin
            n_fail++;
            $display("FAIL %s frame_o pos %0d: got %0b need %0b", tag, p, frame_o, e_frame);
         end
         n_checks++;
         if ($countones(~an_o) > 1) begin
            n_fail++;
            $display("FAIL %s an_onehot pos %0d: got %02h need at most one low bit", tag, p, an_o);
         end
         if (p == chg_pos) d1 = chg_val;
      end
   endtask

   task automatic check_idle(input string tag);
      n_checks++;
      if (an_o !== 8'hFF) begin
         n_fail++;
         $display("FAIL %s an_o: got %02h need ff", tag, an_o);
      end
      n_checks++;
      if (dec_ddp_o !== 8'hFF) begin
         n_fail++;
         $display("FAIL %s dec_ddp_o: got %02h need ff", tag, dec_ddp_o);
      end
      n_checks++;
      if (frame_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s frame_o: got %0b need 0", tag, frame_o);
      end
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      set_all(6'b1_0000_1);
      repeat (5) begin
         @(posedge clk);
         #1;
         check_idle("reset_hold");
      end
      @(negedge clk);
      reset_ni = 1'b1;
      pos = 0;
      exp_q.delete();
      push_frame();
      run_check(FRAME, -1, 6'd0, "reset");
   endtask

   task automatic test_scan_all();
      set_all(6'b1_0011_1);
      push_frame();
      run_check(FRAME, -1, 6'd0, "scan_all");
   endtask

   task automatic test_disabled_digit();
      set_all(6'b1_1000_0);
      d6 = 6'b0_0000_1;
      push_frame();
      run_check(FRAME, -1, 6'd0, "disabled");
   endtask

   task automatic test_snapshot_hold();
      set_all(6'b0_0000_1);
      d1 = 6'b1_0001_1;
      push_frame();
      run_check(FRAME, 3 * SLOT, 6'b1_0010_1, "snap_a");
      push_frame();
      run_check(FRAME, -1, 6'd0, "snap_b");
   endtask

   task automatic test_async_reset();
      set_all(6'b1_0011_1);
      push_frame();
      run_check(2 * SLOT + BL_C + 2, -1, 6'd0, "pre_rst");
      #2;
      reset_ni = 1'b0;
      #1;
      check_idle("async_rst");
      exp_q.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
         check_idle("rst_hold2");
      end
      @(negedge clk);
      reset_ni = 1'b1;
      pos = 0;
      push_frame();
      run_check(FRAME, -1, 6'd0, "post_rst");
   endtask

   task automatic test_hex_sweep();
      logic [3:0] v;
      set_all(6'b0_0000_1);
      for (int i = 0; i < 16; i++) begin
         v  = 4'(i);
         d1 = {1'b1, v, 1'b1};
         push_frame();
         run_check(FRAME, -1, 6'd0, "sweep");
      end
   endtask

   initial begin
      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
      seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
      seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
      seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
      seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
      cur      = '{an: 8'hFF, dec: 8'hFF};
      reset_ni = 1'b0;
      set_all(6'd0);

      test_reset();
      test_scan_all();
      test_disabled_digit();
      test_snapshot_hold();
      test_async_reset();
      test_hex_sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
